// File: rtl/game_board_if.sv
// Move request / board status bundle between a move source and the game_board controller.
interface game_board_if #(
  parameter int SIZE = 3
);
  localparam int N  = SIZE * SIZE;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  logic          new_game;
  logic          move_valid;
  logic [IW-1:0] move_idx;
  logic          move_ready;
  logic          move_accepted;
  logic          move_rejected;
  logic [2*N-1:0] board;
  logic          player;
  logic [CW-1:0] move_count;
  logic          game_over;
  logic          draw;
  logic          winner;

  modport master (
    output new_game, move_valid, move_idx,
    input  move_ready, move_accepted, move_rejected, board, player,
           move_count, game_over, draw, winner
  );

  modport slave (
    input  new_game, move_valid, move_idx,
    output move_ready, move_accepted, move_rejected, board, player,
           move_count, game_over, draw, winner
  );
endinterface

// File: rtl/game_board.sv
// N x N board controller: alternates turns, rejects illegal moves, and scans the four
// lines through the last move (one direction per cycle) for a WIN_LEN run or a draw.
module game_board #(
  parameter int SIZE         = 3,
  parameter int WIN_LEN      = 3,
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  game_board_if.slave bus
);
  localparam int N  = SIZE * SIZE;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;

  state_t         state;
  logic [2*N-1:0] board_q;
  logic           player_q;
  logic [CW-1:0]  cnt_q;
  logic [IW-1:0]  lr, lc;
  logic [1:0]     dir;
  logic           hit, ready_q, acc_q, rej_q, over_q, draw_q, win_q;

  int   sel_idx;
  logic idx_ok, cell_free;

  // Out-of-range indices are compared at full width, never truncated into the board.
  always_comb begin
    idx_ok    = int'(bus.move_idx) < N;
    sel_idx   = idx_ok ? int'(bus.move_idx) : 0;
    cell_free = board_q[2*sel_idx +: 2] == 2'b00;
  end

  int   dr, dc, run, rr, cc, ci;
  logic go, inb, line_hit;

  always_comb begin
    dr = 0;
    dc = 1;
    case (dir)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
  end

  // Run through the last move: walk forward (s=+1) then backward (s=-1), stopping at
  // the first foreign/empty cell or the board edge.
  always_comb begin
    run = 1;
    rr  = 0;
    cc  = 0;
    ci  = 0;
    go  = 1'b1;
    inb = 1'b0;
    for (int s = 0; s < 2; s++) begin
      go = 1'b1;
      for (int k = 1; k < WIN_LEN; k++) begin
        rr  = int'(lr) + (s == 0 ? k : -k) * dr;
        cc  = int'(lc) + (s == 0 ? k : -k) * dc;
        inb = (rr >= 0) && (rr < SIZE) && (cc >= 0) && (cc < SIZE);
        ci  = inb ? rr * SIZE + cc : 0;
        if (go && inb && board_q[2*ci +: 2] == {1'b1, player_q}) run = run + 1;
        else go = 1'b0;
      end
    end
    line_hit = run >= WIN_LEN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PLAY;
      board_q  <= '0;
      player_q <= FIRST_PLAYER;
      cnt_q    <= '0;
      lr       <= '0;
      lc       <= '0;
      dir      <= '0;
      hit      <= 1'b0;
      ready_q  <= 1'b1;
      acc_q    <= 1'b0;
      rej_q    <= 1'b0;
      over_q   <= 1'b0;
      draw_q   <= 1'b0;
      win_q    <= 1'b0;
    end else if (bus.new_game) begin
      state    <= PLAY;
      board_q  <= '0;
      player_q <= FIRST_PLAYER;
      cnt_q    <= '0;
      dir      <= '0;
      hit      <= 1'b0;
      ready_q  <= 1'b1;
      acc_q    <= 1'b0;
      rej_q    <= 1'b0;
      over_q   <= 1'b0;
      draw_q   <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      acc_q <= 1'b0;
      rej_q <= 1'b0;
      case (state)
        PLAY: begin
          if (bus.move_valid) begin
            if (idx_ok && cell_free) begin
              board_q[2*sel_idx +: 2] <= {1'b1, player_q};
              cnt_q   <= cnt_q + CW'(1);
              lr      <= IW'(sel_idx / SIZE);
              lc      <= IW'(sel_idx % SIZE);
              dir     <= 2'd0;
              hit     <= 1'b0;
              acc_q   <= 1'b1;
              ready_q <= 1'b0;
              state   <= CHECK;
            end else begin
              rej_q <= 1'b1;
            end
          end
        end
        CHECK: begin
          hit <= hit | line_hit;
          dir <= dir + 2'd1;
          if (dir == 2'd3) begin
            if (hit | line_hit) begin
              state  <= DONE;
              over_q <= 1'b1;
              win_q  <= player_q;
            end else if (cnt_q == CW'(N)) begin
              state  <= DONE;
              over_q <= 1'b1;
              draw_q <= 1'b1;
            end else begin
              player_q <= ~player_q;
              ready_q  <= 1'b1;
              state    <= PLAY;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.move_ready    = ready_q;
  assign bus.move_accepted = acc_q;
  assign bus.move_rejected = rej_q;
  assign bus.board         = board_q;
  assign bus.player        = player_q;
  assign bus.move_count    = cnt_q;
  assign bus.game_over     = over_q;
  assign bus.draw          = draw_q;
  assign bus.winner        = win_q;
endmodule
